// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button peripheral: status word
// field offsets, region select code and the per-key debounce state encoding.
package btn_pkg;

    localparam int BTN_LEVEL_LSB   = 0;
    localparam int BTN_PRESS_LSB   = 8;
    localparam int BTN_RELEASE_LSB = 16;
    localparam int BTN_MAX         = 8;

    localparam logic [2:0] BTN_REGION_SEL = 3'b111;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } btn_db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One key: two-flop synchroniser, polarity normalisation (1 = pressed) and a
// STABLE/COUNTING debouncer that emits single-cycle rise/fall pulses on accept.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic button_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             RELEASED = ACTIVE_LOW;

    logic             sync_p0;
    logic             sync_p1;
    logic             sync_lvl;
    logic             stable;
    logic             stable_nxt;
    logic             differs;
    logic             at_last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    btn_db_state_t    state;
    btn_db_state_t    state_nxt;

    // Synchroniser starts at the released level so reset never looks like a press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0 <= RELEASED;
            sync_p1 <= RELEASED;
        end else begin
            sync_p0 <= button_i;
            sync_p1 <= sync_p0;
        end
    end

    assign sync_lvl = sync_p1 ^ ACTIVE_LOW;
    assign differs  = (sync_lvl != stable);
    assign at_last  = (cnt == CNT_LAST);
    assign level_o  = stable;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= DB_STABLE;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            stable <= stable_nxt;
        end
    end

    // Counter saturates into the accept, so it never wraps.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stable_nxt = stable;
        case (state)
            DB_STABLE: begin
                if (differs) begin
                    state_nxt = DB_COUNTING;
                    cnt_nxt   = cnt + 1'b1;
                end else begin
                    cnt_nxt = '0;
                end
            end
            DB_COUNTING: begin
                if (!differs) begin
                    state_nxt = DB_STABLE;
                    cnt_nxt   = '0;
                end else if (at_last) begin
                    state_nxt  = DB_STABLE;
                    cnt_nxt    = '0;
                    stable_nxt = sync_lvl;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = DB_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        rise_o = 1'b0;
        fall_o = 1'b0;
        if (state == DB_COUNTING && differs && at_last) begin
            rise_o = sync_lvl;
            fall_o = ~sync_lvl;
        end
    end

endmodule

// File: rtl/button_input_controller.sv
// Memory-mapped push-button peripheral: debounced levels, sticky W1C press events
// and a registered status word. Release events exist only with BTN_RELEASE_EVENTS_EN.
module button_input_controller
    import btn_pkg::*;
#(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_BUTTONS-1:0] buttons_i,
    input  logic                 cs_i,
    input  logic                 wren_i,
    input  logic [31:0]          data_i,
    output logic [31:0]          data_o
);

    logic [N_BUTTONS-1:0] level;
    logic [N_BUTTONS-1:0] rise;
    logic [N_BUTTONS-1:0] fall;
    logic [N_BUTTONS-1:0] press_q;
    logic [N_BUTTONS-1:0] press_clr;
    logic [31:0]          status;
    logic                 wr_en;

    assign wr_en = cs_i & wren_i;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_key
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_debounce (
            .CLK      (CLK),
            .RST      (RST),
            .button_i (buttons_i[i]),
            .level_o  (level[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
        );
    end

    assign press_clr = wr_en ? data_i[BTN_PRESS_LSB +: N_BUTTONS] : '0;

    // Set is OR-ed after the clear so an event arriving with a clear is kept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            press_q <= '0;
        end else begin
            press_q <= (press_q & ~press_clr) | rise;
        end
    end

`ifdef BTN_RELEASE_EVENTS_EN
    logic [N_BUTTONS-1:0] release_q;
    logic [N_BUTTONS-1:0] release_clr;
    logic                 unused_bits;

    assign release_clr = wr_en ? data_i[BTN_RELEASE_LSB +: N_BUTTONS] : '0;
    assign unused_bits = ^data_i;

    always_ff @(posedge CLK) begin
        if (RST) begin
            release_q <= '0;
        end else begin
            release_q <= (release_q & ~release_clr) | fall;
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{data_i, fall};
`endif

    always_comb begin
        status = '0;
        status[BTN_LEVEL_LSB +: N_BUTTONS] = level;
        status[BTN_PRESS_LSB +: N_BUTTONS] = press_q;
`ifdef BTN_RELEASE_EVENTS_EN
        status[BTN_RELEASE_LSB +: N_BUTTONS] = release_q;
`endif
    end

    // Read register captures the pre-update status, giving RAM-like one-cycle latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_o <= '0;
        end else if (cs_i) begin
            data_o <= status;
        end
    end

endmodule

// File: tb/tb_button_input_controller.sv
// Directed plus randomized bench for button_input_controller with a run-length
// reference model; honours BTN_RELEASE_EVENTS_EN when defined.
module tb_button_input_controller;

    localparam int N = 4;
    localparam int D = 4;

`ifdef BTN_RELEASE_EVENTS_EN
    localparam logic [31:0] K0_REL_EXP = 32'h0001_0100;
`else
    localparam logic [31:0] K0_REL_EXP = 32'h0000_0100;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic [N-1:0]  buttons;
    logic          cs;
    logic          wren;
    logic [31:0]   data_in;
    logic [31:0]   data_out;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    button_input_controller #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .buttons_i (buttons),
        .cs_i      (cs),
        .wren_i    (wren),
        .data_i    (data_in),
        .data_o    (data_out)
    );

    // Reference model: pins reach the debouncer two samples late; a level is
    // accepted once it has differed from the stable value for D samples in a row.
    logic [N-1:0] h1 = '1;
    logic [N-1:0] h2 = '1;
    logic [N-1:0] m_stable = '0;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_rel = '0;
    logic [N-1:0] m_sync;
    logic [N-1:0] set_p;
    logic [N-1:0] set_r;
    logic [N-1:0] clr_p;
    logic [N-1:0] clr_r;
    logic [31:0]  m_data = '0;
    int           run [N];

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[N-1:0]    = m_stable;
        s[8+N-1:8]  = m_press;
`ifdef BTN_RELEASE_EVENTS_EN
        s[16+N-1:16] = m_rel;
`endif
        return s;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            h1 = '1;
            h2 = '1;
            m_stable = '0;
            m_press  = '0;
            m_rel    = '0;
            m_data   = '0;
            for (int i = 0; i < N; i++) run[i] = 0;
        end else begin
            if (cs) m_data = m_status();
            m_sync = ~h2;
            h2 = h1;
            h1 = buttons;
            set_p = '0;
            set_r = '0;
            for (int i = 0; i < N; i++) begin
                if (m_sync[i] != m_stable[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == D) begin
                        m_stable[i] = m_sync[i];
                        run[i] = 0;
                        if (m_sync[i]) set_p[i] = 1'b1;
                        else           set_r[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            clr_p = (cs && wren) ? data_in[8+N-1:8]   : '0;
            clr_r = (cs && wren) ? data_in[16+N-1:16] : '0;
            m_press = (m_press & ~clr_p) | set_p;
`ifdef BTN_RELEASE_EVENTS_EN
            m_rel = (m_rel & ~clr_r) | set_r;
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n, input string tag);
        repeat (n) begin
            @(negedge CLK);
            chk(tag, data_out, m_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        buttons = '1;
        cs = 1'b0;
        wren = 1'b0;
        data_in = '0;
        cyc(3, "in_reset");
        RST = 1'b0;
        chk("reset_value", data_out, 32'h0);

        cs = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc(1, "idle_model");
            chk("idle_zero", data_out, 32'h0);
        end

        buttons[0] = 1'b0;
        cyc(6, "k0_model");
        chk("k0_before_read", data_out, 32'h0);
        cyc(1, "k0_model");
        chk("k0_press", data_out, 32'h0000_0101);

        for (int k = 0; k < 20; k++) begin
            buttons[1] = ~buttons[1];
            cyc(2, "bounce_model");
            chk("bounce_reject", data_out, 32'h0000_0101);
        end
        buttons[1] = 1'b1;
        cyc(10, "bounce_model");
        chk("bounce_after", data_out, 32'h0000_0101);

        buttons[0] = 1'b1;
        cyc(8, "k0_rel_model");
        chk("k0_release", data_out, K0_REL_EXP);
        wren = 1'b1;
        data_in = 32'h0001_0100;
        cyc(1, "k0_clr_model");
        chk("k0_clr_same_cycle", data_out, K0_REL_EXP);
        wren = 1'b0;
        data_in = '0;
        cyc(1, "k0_clr_model");
        chk("k0_cleared", data_out, 32'h0);

        buttons[2] = 1'b0;
        cyc(8, "k2_model");
        chk("k2_press", data_out, 32'h0000_0404);
        wren = 1'b1;
        data_in = 32'h0000_0400;
        cyc(1, "k2_wr_model");
        chk("k2_read_in_write", data_out, 32'h0000_0404);
        wren = 1'b0;
        data_in = '0;
        cyc(1, "k2_wr_model");
        chk("k2_cleared", data_out, 32'h0000_0004);

        buttons[3] = 1'b0;
        cyc(5, "k3_model");
        wren = 1'b1;
        data_in = 32'h0000_0800;
        cyc(1, "k3_model");
        wren = 1'b0;
        data_in = '0;
        chk("k3_pre", data_out, 32'h0000_0004);
        cyc(1, "k3_model");
        chk("k3_set_wins", data_out, 32'h0000_080C);

        buttons[1] = 1'b0;
        cyc(3, "k1_model");
        RST = 1'b1;
        cyc(2, "k1_in_reset");
        RST = 1'b0;
        chk("k1_reset_clears", data_out, 32'h0);
        cyc(6, "k1_model");
        chk("k1_still_pending", data_out, 32'h0);
        cyc(1, "k1_model");
        chk("k1_after_reset", data_out, 32'h0000_0E0E);

        for (int k = 0; k < 600; k++) begin
            int b;
            if ($urandom_range(5) == 0) begin
                b = int'($urandom_range(N - 1));
                buttons[b] = ~buttons[b];
            end
            cs = ($urandom_range(3) != 0);
            wren = ($urandom_range(4) == 0);
            data_in = $urandom;
            cyc(1, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
